// File: rtl/location_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : location_scanner
// Description : Walks a programmable rectangular window of the game world one
//               coordinate per valid/ready handshake, with configurable X/Y
//               stride and row-major or column-major order. Pulses FRAME_DONE
//               after the final coordinate of the window is accepted.
//               Optional macro LOCATION_SCANNER_CONTINUOUS_EN: rescan the
//               window endlessly and count completed frames on FRAME_CNT.
// Revision    : 1.0 - initial release
// ============================================================================
module location_scanner #(
    parameter int X_BITS   = 10,
    parameter int Y_BITS   = 9,
    parameter int MAX_X    = 640,
    parameter int MAX_Y    = 480,
    parameter int STRIDE_X = 1,
    parameter int STRIDE_Y = 1
) (
    input  logic              CLK,
    input  logic              RESET_SIM_N,
    input  logic              START,
    input  logic              STOP,
    input  logic              HOLD,
    input  logic              COL_MAJOR,
    input  logic [X_BITS-1:0] WIN_X0,
    input  logic [X_BITS-1:0] WIN_X1,
    input  logic [Y_BITS-1:0] WIN_Y0,
    input  logic [Y_BITS-1:0] WIN_Y1,
    input  logic              LOC_READY,
    output logic              LOC_VALID,
    output logic [X_BITS-1:0] curX,
    output logic [Y_BITS-1:0] curY,
    output logic              LINE_END,
    output logic              FRAME_END,
    output logic              FRAME_DONE,
    output logic              BUSY,
    output logic              START_ERR
`ifdef LOCATION_SCANNER_CONTINUOUS_EN
    ,
    output logic [7:0]        FRAME_CNT
`endif
);

    localparam logic [X_BITS-1:0] c_x_last = X_BITS'(MAX_X - 1);
    localparam logic [Y_BITS-1:0] c_y_last = Y_BITS'(MAX_Y - 1);
    // One extra bit so a step past the top of the coordinate range is seen
    // as "beyond the bound" rather than wrapping back into the window.
    localparam logic [X_BITS:0]   c_step_x = (X_BITS + 1)'(STRIDE_X);
    localparam logic [Y_BITS:0]   c_step_y = (Y_BITS + 1)'(STRIDE_Y);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [X_BITS-1:0] cur_x_q, cur_x_d;
    logic [Y_BITS-1:0] cur_y_q, cur_y_d;
    logic [X_BITS-1:0] win_x0_q, win_x0_d, win_x1_q, win_x1_d;
    logic [Y_BITS-1:0] win_y0_q, win_y0_d, win_y1_q, win_y1_d;
    logic              col_major_q, col_major_d;
    logic              frame_done_q, frame_done_d;
    logic              start_err_q, start_err_d;
`ifdef LOCATION_SCANNER_CONTINUOUS_EN
    logic [7:0]        frame_cnt_q, frame_cnt_d;
`endif

    logic [X_BITS:0]   w_nx;
    logic [Y_BITS:0]   w_ny;
    logic              w_x_over;
    logic              w_y_over;
    logic              w_fast_over;
    logic              w_frame_over;
    logic              w_valid;
    logic              w_accept;
    logic              w_start_ok;

    // Candidate next coordinate and bound tests against the latched window.
    always_comb begin
        w_nx         = {1'b0, cur_x_q} + c_step_x;
        w_ny         = {1'b0, cur_y_q} + c_step_y;
        w_x_over     = (w_nx > {1'b0, win_x1_q});
        w_y_over     = (w_ny > {1'b0, win_y1_q});
        w_fast_over  = col_major_q ? w_y_over : w_x_over;
        w_frame_over = w_x_over & w_y_over;
        w_valid      = (state_q == S_SCAN);
        w_accept     = w_valid & LOC_READY & ~HOLD & ~STOP;
        w_start_ok   = (WIN_X0 <= WIN_X1) && (32'(WIN_X1) < 32'(MAX_X)) &&
                       (WIN_Y0 <= WIN_Y1) && (32'(WIN_Y1) < 32'(MAX_Y));
    end

    // State register; reset restores the full-world window parked on its last pixel.
    always_ff @(posedge CLK or negedge RESET_SIM_N) begin
        if (!RESET_SIM_N) begin
            state_q      <= S_IDLE;
            cur_x_q      <= c_x_last;
            cur_y_q      <= c_y_last;
            win_x0_q     <= '0;
            win_x1_q     <= c_x_last;
            win_y0_q     <= '0;
            win_y1_q     <= c_y_last;
            col_major_q  <= 1'b0;
            frame_done_q <= 1'b0;
            start_err_q  <= 1'b0;
`ifdef LOCATION_SCANNER_CONTINUOUS_EN
            frame_cnt_q  <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            win_x0_q     <= win_x0_d;
            win_x1_q     <= win_x1_d;
            win_y0_q     <= win_y0_d;
            win_y1_q     <= win_y1_d;
            col_major_q  <= col_major_d;
            frame_done_q <= frame_done_d;
            start_err_q  <= start_err_d;
`ifdef LOCATION_SCANNER_CONTINUOUS_EN
            frame_cnt_q  <= frame_cnt_d;
`endif
        end
    end

    // Next-state logic: start/reject in IDLE; STOP, freeze or step in SCAN.
    always_comb begin
        state_d      = state_q;
        cur_x_d      = cur_x_q;
        cur_y_d      = cur_y_q;
        win_x0_d     = win_x0_q;
        win_x1_d     = win_x1_q;
        win_y0_d     = win_y0_q;
        win_y1_d     = win_y1_q;
        col_major_d  = col_major_q;
        frame_done_d = 1'b0;
        start_err_d  = 1'b0;
`ifdef LOCATION_SCANNER_CONTINUOUS_EN
        frame_cnt_d  = frame_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (START && !HOLD) begin
                    if (w_start_ok) begin
                        win_x0_d    = WIN_X0;
                        win_x1_d    = WIN_X1;
                        win_y0_d    = WIN_Y0;
                        win_y1_d    = WIN_Y1;
                        col_major_d = COL_MAJOR;
                        cur_x_d     = WIN_X0;
                        cur_y_d     = WIN_Y0;
                        state_d     = S_SCAN;
                    end else begin
                        start_err_d = 1'b1;
                    end
                end
            end
            S_SCAN: begin
                if (STOP) begin
                    state_d = S_IDLE;
                end else if (w_accept) begin
                    if (w_frame_over) begin
                        frame_done_d = 1'b1;
`ifdef LOCATION_SCANNER_CONTINUOUS_EN
                        cur_x_d      = win_x0_q;
                        cur_y_d      = win_y0_q;
                        frame_cnt_d  = frame_cnt_q + 8'd1;
`else
                        state_d      = S_IDLE;
`endif
                    end else if (!col_major_q) begin
                        if (!w_x_over) begin
                            cur_x_d = w_nx[X_BITS-1:0];
                        end else begin
                            cur_x_d = win_x0_q;
                            cur_y_d = w_ny[Y_BITS-1:0];
                        end
                    end else begin
                        if (!w_y_over) begin
                            cur_y_d = w_ny[Y_BITS-1:0];
                        end else begin
                            cur_y_d = win_y0_q;
                            cur_x_d = w_nx[X_BITS-1:0];
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign LOC_VALID  = w_valid;
    assign BUSY       = w_valid;
    assign curX       = cur_x_q;
    assign curY       = cur_y_q;
    assign LINE_END   = w_valid & w_fast_over;
    assign FRAME_END  = w_valid & w_frame_over;
    assign FRAME_DONE = frame_done_q;
    assign START_ERR  = start_err_q;
`ifdef LOCATION_SCANNER_CONTINUOUS_EN
    assign FRAME_CNT  = frame_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_location_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_location_scanner
// Description : Scoreboard bench for location_scanner. Two instances share
//               stimulus (stride 1/1 and stride 3/2); the expected coordinate
//               stream is built from nested window loops and checked by a
//               monitor on every accept. Honours LOCATION_SCANNER_CONTINUOUS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_location_scanner;

    localparam int MX  = 8;
    localparam int MY  = 4;
    localparam int SXA = 1;
    localparam int SYA = 1;
    localparam int SXB = 3;
    localparam int SYB = 2;

    typedef struct packed {
        int   x;
        int   y;
        logic le;
        logic fe;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic       hold  = 1'b0;
    logic       col   = 1'b0;
    logic       ready = 1'b0;
    logic [3:0] wx0 = 4'd0, wx1 = 4'd0;
    logic [2:0] wy0 = 3'd0, wy1 = 3'd0;

    logic       valid_a, le_a, fe_a, done_a, busy_a, err_a;
    logic       valid_b, le_b, fe_b, done_b, busy_b, err_b;
    logic [3:0] curx_a, curx_b;
    logic [2:0] cury_a, cury_b;
`ifdef LOCATION_SCANNER_CONTINUOUS_EN
    logic [7:0] cnt_a, cnt_b;
`endif

    exp_t       qa[$], qb[$], ta[$], tb[$];
    int         n_vec = 0;
    int         n_err = 0;
    bit         done_exp[2];
    logic [7:0] cnt_exp[2];
    int         frames[2];

    always #5 clk = ~clk;

    location_scanner #(.X_BITS(4), .Y_BITS(3), .MAX_X(MX), .MAX_Y(MY),
                       .STRIDE_X(SXA), .STRIDE_Y(SYA)) u_dut_a (
        .CLK(clk), .RESET_SIM_N(rst_n), .START(start), .STOP(stop), .HOLD(hold),
        .COL_MAJOR(col), .WIN_X0(wx0), .WIN_X1(wx1), .WIN_Y0(wy0), .WIN_Y1(wy1),
        .LOC_READY(ready), .LOC_VALID(valid_a), .curX(curx_a), .curY(cury_a),
        .LINE_END(le_a), .FRAME_END(fe_a), .FRAME_DONE(done_a), .BUSY(busy_a),
        .START_ERR(err_a)
`ifdef LOCATION_SCANNER_CONTINUOUS_EN
        , .FRAME_CNT(cnt_a)
`endif
    );

    location_scanner #(.X_BITS(4), .Y_BITS(3), .MAX_X(MX), .MAX_Y(MY),
                       .STRIDE_X(SXB), .STRIDE_Y(SYB)) u_dut_b (
        .CLK(clk), .RESET_SIM_N(rst_n), .START(start), .STOP(stop), .HOLD(hold),
        .COL_MAJOR(col), .WIN_X0(wx0), .WIN_X1(wx1), .WIN_Y0(wy0), .WIN_Y1(wy1),
        .LOC_READY(ready), .LOC_VALID(valid_b), .curX(curx_b), .curY(cury_b),
        .LINE_END(le_b), .FRAME_END(fe_b), .FRAME_DONE(done_b), .BUSY(busy_b),
        .START_ERR(err_b)
`ifdef LOCATION_SCANNER_CONTINUOUS_EN
        , .FRAME_CNT(cnt_b)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: actual %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Reference walk: slow axis outer loop, fast axis inner loop.
    task automatic push_seq(input int w, input int x0, input int x1, input int y0,
                            input int y1, input bit cm, input int sx, input int sy);
        exp_t e;
        int   f0, f1, fs, s0, s1, ss;
        if (cm) begin
            f0 = y0; f1 = y1; fs = sy; s0 = x0; s1 = x1; ss = sx;
        end else begin
            f0 = x0; f1 = x1; fs = sx; s0 = y0; s1 = y1; ss = sy;
        end
        if (w == 0) begin qa.delete(); ta.delete(); end
        else        begin qb.delete(); tb.delete(); end
        for (int s = s0; s <= s1; s += ss) begin
            for (int f = f0; f <= f1; f += fs) begin
                e.x  = cm ? s : f;
                e.y  = cm ? f : s;
                e.le = (f + fs > f1);
                e.fe = (f + fs > f1) && (s + ss > s1);
                if (w == 0) begin qa.push_back(e); ta.push_back(e); end
                else        begin qb.push_back(e); tb.push_back(e); end
            end
        end
    endtask

    task automatic monitor(input int w, input logic v, input logic [3:0] x, input logic [2:0] y,
                           input logic le, input logic fe, input logic done);
        exp_t e;
        int   sz;
        if (!rst_n) begin
            done_exp[w] = 1'b0;
            cnt_exp[w]  = 8'd0;
            return;
        end
        if (done || done_exp[w]) begin
            check($sformatf("frame_done[%0d]", w), done, done_exp[w]);
`ifdef LOCATION_SCANNER_CONTINUOUS_EN
            if (done_exp[w]) begin
                cnt_exp[w] = cnt_exp[w] + 8'd1;
                check($sformatf("frame_cnt[%0d]", w), (w == 0) ? cnt_a : cnt_b, cnt_exp[w]);
                check($sformatf("valid_no_bubble[%0d]", w), v, 1);
            end
`endif
        end
        done_exp[w] = 1'b0;
        if (v && ready && !hold && !stop) begin
            sz = (w == 0) ? qa.size() : qb.size();
            if (sz == 0) begin
                check($sformatf("unexpected_accept[%0d]", w), 1, 0);
            end else begin
                e = (w == 0) ? qa.pop_front() : qb.pop_front();
                check($sformatf("curX[%0d]", w), x, e.x);
                check($sformatf("curY[%0d]", w), y, e.y);
                check($sformatf("line_end[%0d] at (%0d,%0d)", w, e.x, e.y), le, e.le);
                check($sformatf("frame_end[%0d] at (%0d,%0d)", w, e.x, e.y), fe, e.fe);
                if (e.fe) begin
                    done_exp[w] = 1'b1;
                    frames[w]++;
`ifdef LOCATION_SCANNER_CONTINUOUS_EN
                    if (w == 0) foreach (ta[i]) qa.push_back(ta[i]);
                    else        foreach (tb[i]) qb.push_back(tb[i]);
`endif
                end
            end
        end
    endtask

    // Scoreboard side: sample half a cycle away from the active edge.
    always @(negedge clk) begin
        monitor(0, valid_a, curx_a, cury_a, le_a, fe_a, done_a);
        monitor(1, valid_b, curx_b, cury_b, le_b, fe_b, done_b);
    end

    task automatic reset_dut();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0; ready = 1'b0;
        #3;
        check("rst curX", curx_a, MX - 1);
        check("rst curY", cury_a, MY - 1);
        check("rst curX_b", curx_b, MX - 1);
        check("rst valid", valid_a, 0);
        check("rst busy", busy_a, 0);
        check("rst line_end", le_a, 0);
        check("rst frame_end", fe_a, 0);
        check("rst frame_done", done_a, 0);
        check("rst start_err", err_a, 0);
`ifdef LOCATION_SCANNER_CONTINUOUS_EN
        check("rst frame_cnt", cnt_a, 0);
`endif
        qa.delete(); qb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic do_start(input int x0, input int x1, input int y0, input int y1,
                            input bit cm, output bit legal);
        logic [3:0] px;
        logic [2:0] py;
        legal = (x0 <= x1) && (x1 < MX) && (y0 <= y1) && (y1 < MY);
        @(posedge clk); #1;
        px  = curx_a; py = cury_a;
        wx0 = 4'(x0); wx1 = 4'(x1); wy0 = 3'(y0); wy1 = 3'(y1);
        col = cm; start = 1'b1; hold = 1'b0; stop = 1'b0;
        if (legal) begin
            push_seq(0, x0, x1, y0, y1, cm, SXA, SYA);
            push_seq(1, x0, x1, y0, y1, cm, SXB, SYB);
        end
        @(posedge clk); #1;
        start = 1'b0;
        check("busy after start", busy_a, legal);
        check("busy_b after start", busy_b, legal);
        check("start_err", err_a, !legal);
        check("start_err_b", err_b, !legal);
        if (!legal) begin
            check("curX kept on reject", curx_a, px);
            check("curY kept on reject", cury_a, py);
            @(posedge clk); #1;
            check("start_err one cycle", err_a, 0);
            check("busy stays 0 on reject", busy_a, 0);
        end
    endtask

    task automatic run_frame(input int ready_pct, input int hold_pct, input bit allow_stop);
        int  cyc;
        int  fa, fb;
        bit  fin;
        fa  = frames[0]; fb = frames[1];
        fin = 1'b0;
        for (cyc = 0; cyc < 600 && !fin; cyc++) begin
            @(posedge clk); #1;
            if (start) begin
                start = 1'b0;
                check("start ignored in scan", err_a, 0);
                check("start ignored in scan b", err_b, 0);
            end
            if (stop) begin
                stop = 1'b0;
                qa.delete(); qb.delete();
            end
            fin = !busy_a && !busy_b && (qa.size() == 0) && (qb.size() == 0);
            if (!fin) begin
                ready = ($urandom_range(99, 0) < ready_pct);
                hold  = ($urandom_range(99, 0) < hold_pct);
`ifdef LOCATION_SCANNER_CONTINUOUS_EN
                if (frames[0] >= fa + 2 && frames[1] >= fb + 2) stop = 1'b1;
`endif
                if (allow_stop && $urandom_range(99, 0) < 3) stop = 1'b1;
                if (!stop && busy_a && busy_b && $urandom_range(99, 0) < 5) begin
                    start = 1'b1;
                    wx0 = 4'($urandom_range(15, 0)); wx1 = 4'($urandom_range(15, 0));
                    wy0 = 3'($urandom_range(7, 0));  wy1 = 3'($urandom_range(7, 0));
                end
            end
        end
        if (!fin) begin
            check("frame completes within budget", 0, 1);
            start = 1'b0; stop = 1'b1;
            @(posedge clk); #1;
            stop = 1'b0;
            qa.delete(); qb.delete();
        end
        ready = 1'b0; hold = 1'b0;
    endtask

    initial begin
        bit legal;
        int x0, x1, y0, y1;
        #1;
        reset_dut();

        // Full world, always ready.
        do_start(0, 7, 0, 3, 1'b0, legal);
        run_frame(100, 0, 1'b0);
        // Stride overshoot on a single row.
        do_start(1, 6, 2, 2, 1'b0, legal);
        run_frame(100, 0, 1'b0);
        // Column-major 2x2.
        do_start(2, 3, 0, 1, 1'b1, legal);
        run_frame(100, 0, 1'b0);
        // Rejected windows.
        do_start(5, 4, 0, 3, 1'b0, legal);
        do_start(0, 7, 0, 4, 1'b0, legal);
        // Single point.
        do_start(6, 6, 1, 1, 1'b0, legal);
        run_frame(60, 0, 1'b0);

        // START while HOLD is high is ignored in IDLE.
        @(posedge clk); #1;
        wx0 = 4'd0; wx1 = 4'd7; wy0 = 3'd0; wy1 = 3'd3;
        hold = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; hold = 1'b0;
        check("start with hold: busy", busy_a, 0);
        check("start with hold: err", err_a, 0);

        // Freeze at (3,1), then STOP together with READY.
        do_start(0, 7, 0, 3, 1'b0, legal);
        ready = 1'b1;
        for (int i = 0; i < 40 && !(curx_a == 4'd3 && cury_a == 3'd1); i++) begin
            @(posedge clk); #1;
        end
        check("reached (3,1)", (curx_a == 4'd3 && cury_a == 3'd1), 1);
        hold = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("hold curX", curx_a, 3);
            check("hold curY", cury_a, 1);
            check("hold valid", valid_a, 1);
        end
        hold = 1'b0; stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0; ready = 1'b0;
        qa.delete(); qb.delete();
        check("stop valid", valid_a, 0);
        check("stop busy", busy_a, 0);
        @(posedge clk); #1;
        check("no frame_done after stop", done_a, 0);

        // Reset in the middle of a column-major scan.
        do_start(0, 7, 0, 3, 1'b1, legal);
        ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        reset_dut();

`ifdef LOCATION_SCANNER_CONTINUOUS_EN
        // Two-pixel window rescanned: three frames after six accepts.
        do_start(0, 1, 0, 0, 1'b0, legal);
        ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("frame_cnt after 6 accepts", cnt_a, 3);
        check("still valid", valid_a, 1);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0; ready = 1'b0;
        qa.delete(); qb.delete();
`endif

        // Randomised windows, modes, back-pressure, HOLD and STOP.
        for (int it = 0; it < 30; it++) begin
            x0 = $urandom_range(7, 0); x1 = $urandom_range(7, x0);
            y0 = $urandom_range(3, 0); y1 = $urandom_range(3, y0);
            if ($urandom_range(99, 0) < 15) begin
                x1 = $urandom_range(15, 0);
                y1 = $urandom_range(7, 0);
            end
            do_start(x0, x1, y0, y1, 1'($urandom_range(1, 0)), legal);
            if (legal) run_frame(70, 10, 1'b1);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        n_err++;
        $display("FAIL watchdog: simulation did not finish, actual timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
